aes_round_scheduler: RTL and testbench
======================================

# aes_round_scheduler

Slot scheduler for the iterative AES-128 round pipeline. Each cycle it decides what the round-input mux register loads: a fresh block from the requester, or the recirculated result of a block still in flight. It tracks round number, Rcon and a requester tag for every pipeline slot. It drives the mux select, empty flag, Rcon and last-round control into the datapath, and flags completed blocks at the exit.

## Interface
- PIPE_DEPTH, 2: cycles for one round to travel from the mux register back to the recirculation input (D); ≥1
- TAG_W, 4: width of the requester tag carried with each block
- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  requester offers a block (already key-whitened)
- in_tag  in  TAG_W  tag for the offered block
- in_ready  out  1  block is accepted this cycle when in_valid && in_ready
- flush  in  1  synchronous; invalidates every slot
- mux_sel_new  out  1  1 = mux loads the new block; 0 = mux loads the recirculated block
- mux_empty  out  1  slot loaded this cycle carries no block
- mux_rcon  out  8  Rcon for the round the loaded slot executes next
- mux_last_round  out  1  loaded slot executes round 10 (no MixColumns)
- out_valid  out  1  block at the recirculation input has finished round 10
- out_tag  out  TAG_W  tag of the finishing block
- inflight  out  $clog2(PIPE_DEPTH+1)  number of valid slots

## Operation
- The slot tracker is a D-entry shift register {valid, round[3:0], rcon[7:0], tag}. It mirrors the datapath. The tail entry describes the slot currently at the recirculation input.
- Each cycle the decision is made from the tail:
  - **Recirculate:** tail valid and round<10. Set mux_sel_new=0 and mux_empty=0. Head gets round+1 and rcon=xtime(rcon), where xtime gives 0x80→0x1B. The tag is kept. in_ready=0.
  - **Free slot:** tail invalid, or round==10. Set in_ready=1 and mux_sel_new=1.
    - If in_valid: head gets {1, round 1, rcon 0x01, in_tag} and mux_empty=0.
    - Otherwise: head gets {0, 0, 0x00, 0} and mux_empty=1.
- mux_rcon and mux_last_round describe the head value being written. mux_last_round=1 iff that head round==10.
- out_valid=1 iff tail valid && tail round==10. out_tag=tail tag, or 0 when out_valid=0. There is no output backpressure: the consumer must capture the result in the out_valid cycle.
- A finishing slot is reused in the same cycle. Completion and admission may coincide.
- Rcon sequence is 01,02,04,08,10,20,40,80,1B,36. Round counter width is 4 bits; it never exceeds 10.
- inflight is a counter, not a popcount:
  - +1 on accept without completion.
  - −1 on completion without accept.
  - Unchanged when both or neither occur.
- **flush:**
  - All slots invalid on the next edge, inflight=0.
  - in_ready=0 and mux_empty=1 during the flush cycle, so no accept.
  - out_valid is suppressed (forced 0) during the flush cycle.
- **Reset (asynchronous, any time including mid-block):**
  - All slots cleared and inflight=0.
  - Outputs while reset is asserted: in_ready=1, mux_sel_new=1, mux_empty=1, mux_rcon=0x00, mux_last_round=0, out_valid=0, out_tag=0.
  - Blocks in flight are lost.

## Timing
- Control outputs are combinational from tail state plus in_valid/in_tag/flush. There are no combinational paths from in_valid to in_ready.
- Block accepted at cycle t:
  - executes round r from decision cycle t+(r−1)·D;
  - last_round at t+9·D;
  - out_valid at t+10·D.
- Throughput is up to D blocks in flight. A new block can enter only in empty or completing slots.

## Structure
- **Package aes_sched_pkg:**
  - NUM_ROUNDS=10
  - RCON_FIRST=8'h01
  - RCON_LAST=8'h36
  - slot_t struct {valid, round, rcon, tag}; tag width is parameterised, so keep tag outside the struct if the tool lacks parameterised types
  - function xtime
- **Sub-module aes_slot_tracker:** the D-entry slot shift register, with head-write and flush.
- **Top (aes_round_scheduler):** decision logic and the inflight counter.

## Test plan
- **Single block (D=2):** tag 3 accepted at cycle 0. Required:
  - mux_rcon = 01 at 0, 02 at 2, …, 1B at 16, 36 at 18;
  - mux_last_round only at 18;
  - out_valid with out_tag=3 at cycle 20 only.
- **Back-to-back (D=2):** tags 1 and 2 accepted at cycles 0 and 1. Required:
  - in_ready=0 for cycles 2–19;
  - out_valid tag 1 at 20 and tag 2 at 21;
  - inflight 0→1→2, returning to 0 at 22.
- **Completion plus admission:** tag 5 offered at cycle 20 in the single-block case. Required: out_valid(tag 3) and accept(tag 5) both in cycle 20; mux_rcon=01 and inflight stays 1.
- **Idle:** in_valid=0 for 50 cycles. Required: mux_empty=1, mux_sel_new=1 and out_valid=0 throughout.
- **flush:** asserted at cycle 7 with 2 blocks in flight. Required: inflight=0 at cycle 8, and no out_valid ever for the flushed tags.
- **Reset mid-operation:** resetn pulsed low at cycle 11. Required: all outputs at reset values immediately, then a new block accepted right after release completes 10·D cycles later with the correct Rcon sequence.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types, constants and the Rcon helper for the AES round scheduler.
package aes_sched_pkg;

   localparam int             NUM_ROUNDS = 10;
   localparam logic [3:0]     ROUND_LAST = 4'(NUM_ROUNDS);
   localparam logic [7:0]     RCON_FIRST = 8'h01;
   localparam logic [7:0]     RCON_LAST  = 8'h36;

   // Tag width is parameterised per instance, so the tag travels beside the struct.
   typedef struct packed {
      logic       valid;
      logic [3:0] round;
      logic [7:0] rcon;
   } slot_t;

   // GF(2^8) doubling; walks the Rcon sequence 01,02,...,80,1B,36.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

endpackage

// File: rtl/aes_slot_tracker.sv
// Shift register mirroring the datapath slots; entry 0 is the head, the last entry is the tail.
module aes_slot_tracker
   import aes_sched_pkg::*;
#(
   parameter int PIPE_DEPTH = 2,
   parameter int TAG_W      = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             flush,
   input  slot_t            head_slot,
   input  logic [TAG_W-1:0] head_tag,
   output slot_t            tail_slot,
   output logic [TAG_W-1:0] tail_tag
);

   slot_t            slots [PIPE_DEPTH];
   logic [TAG_W-1:0] tags  [PIPE_DEPTH];

   // Advance every slot one stage per cycle, writing the head; reset and flush empty all slots.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            slots[i] <= '0;
            tags[i]  <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            slots[i] <= '0;
            tags[i]  <= '0;
         end
      end else begin
         slots[0] <= head_slot;
         tags[0]  <= head_tag;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            slots[i] <= slots[i-1];
            tags[i]  <= tags[i-1];
         end
      end
   end

   assign tail_slot = slots[PIPE_DEPTH-1];
   assign tail_tag  = tags[PIPE_DEPTH-1];

endmodule

// File: rtl/aes_round_scheduler.sv
// Decides each cycle whether the round mux loads a new block or recirculates the tail block.
module aes_round_scheduler
   import aes_sched_pkg::*;
#(
   parameter int PIPE_DEPTH = 2,
   parameter int TAG_W      = 4,
   localparam int CNT_W     = $clog2(PIPE_DEPTH + 1)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             in_valid,
   input  logic [TAG_W-1:0] in_tag,
   output logic             in_ready,
   input  logic             flush,
   output logic             mux_sel_new,
   output logic             mux_empty,
   output logic [7:0]       mux_rcon,
   output logic             mux_last_round,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag,
   output logic [CNT_W-1:0] inflight
);

   slot_t            head_slot;
   slot_t            tail_slot;
   logic [TAG_W-1:0] head_tag;
   logic [TAG_W-1:0] tail_tag;
   logic             tail_done;
   logic             accept;
   logic             complete;

   aes_slot_tracker #(
      .PIPE_DEPTH (PIPE_DEPTH),
      .TAG_W      (TAG_W)
   ) u_tracker (
      .clock     (clock),
      .resetn    (resetn),
      .flush     (flush),
      .head_slot (head_slot),
      .head_tag  (head_tag),
      .tail_slot (tail_slot),
      .tail_tag  (tail_tag)
   );

   assign tail_done = tail_slot.valid && (tail_slot.round == ROUND_LAST);

   // Slot decision: recirculate an unfinished tail, otherwise offer the slot to the requester.
   always_comb begin
      in_ready    = 1'b1;
      mux_sel_new = 1'b1;
      mux_empty   = 1'b1;
      head_slot   = '0;
      head_tag    = '0;
      accept      = 1'b0;
      if (tail_slot.valid && !tail_done) begin
         mux_sel_new = 1'b0;
         in_ready    = 1'b0;
         if (!flush) begin
            mux_empty       = 1'b0;
            head_slot.valid = 1'b1;
            head_slot.round = tail_slot.round + 4'd1;
            head_slot.rcon  = xtime(tail_slot.rcon);
            head_tag        = tail_tag;
         end
      end else begin
         in_ready = !flush;
         if (in_valid && !flush) begin
            accept          = 1'b1;
            mux_empty       = 1'b0;
            head_slot.valid = 1'b1;
            head_slot.round = 4'd1;
            head_slot.rcon  = RCON_FIRST;
            head_tag        = in_tag;
         end
      end
      if (!resetn) begin
         in_ready    = 1'b1;
         mux_sel_new = 1'b1;
         mux_empty   = 1'b1;
         head_slot   = '0;
         head_tag    = '0;
         accept      = 1'b0;
      end
   end

   assign complete       = tail_done && !flush;
   assign out_valid      = complete;
   assign out_tag        = complete ? tail_tag : '0;
   assign mux_rcon       = head_slot.rcon;
   assign mux_last_round = head_slot.valid && (head_slot.round == ROUND_LAST);

   // Occupancy counter: admissions add, completions subtract, flush clears.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         inflight <= '0;
      end else if (flush) begin
         inflight <= '0;
      end else if (accept && !complete) begin
         inflight <= inflight + CNT_W'(1);
      end else if (complete && !accept) begin
         inflight <= inflight - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Directed bench for aes_round_scheduler with D=2 and 4-bit tags.
module tb_aes_round_scheduler;
   import aes_sched_pkg::*;

   logic       clock;
   logic       resetn;
   logic       inValid;
   logic [3:0] inTag;
   logic       flush;
   logic       inReady;
   logic       muxSelNew;
   logic       muxEmpty;
   logic [7:0] muxRcon;
   logic       muxLastRound;
   logic       outValid;
   logic [3:0] outTag;
   logic [1:0] inflight;

   int vectors    = 0;
   int miscompares = 0;
   int badCount;

   logic [7:0] rconTab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, RCON_LAST};

   aes_round_scheduler #(
      .PIPE_DEPTH (2),
      .TAG_W      (4)
   ) dut (
      .clock          (clock),
      .resetn         (resetn),
      .in_valid       (inValid),
      .in_tag         (inTag),
      .in_ready       (inReady),
      .flush          (flush),
      .mux_sel_new    (muxSelNew),
      .mux_empty      (muxEmpty),
      .mux_rcon       (muxRcon),
      .mux_last_round (muxLastRound),
      .out_valid      (outValid),
      .out_tag        (outTag),
      .inflight       (inflight)
   );

   // Free-running clock, 10 time-unit period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive inputs on the falling edge and let the combinational outputs settle.
   task automatic applyStimulus(input logic v, input logic [3:0] t, input logic f);
      @(negedge clock);
      inValid = v;
      inTag   = t;
      flush   = f;
      #1;
   endtask

   // Compare one observed value with its expected value.
   task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, "_ready"},  32'(inReady), 32'd1);
      checkOutput({name, "_sel"},    32'(muxSelNew), 32'd1);
      checkOutput({name, "_empty"},  32'(muxEmpty), 32'd1);
      checkOutput({name, "_rcon"},   32'(muxRcon), 32'h00);
      checkOutput({name, "_last"},   32'(muxLastRound), 32'd0);
      checkOutput({name, "_ovalid"}, 32'(outValid), 32'd0);
      checkOutput({name, "_otag"},   32'(outTag), 32'd0);
      checkOutput({name, "_infl"},   32'(inflight), 32'd0);
   endtask

   initial begin
      resetn  = 1'b0;
      inValid = 1'b1;
      inTag   = 4'h6;
      flush   = 1'b0;
      #1;
      $display("[TB] reset state");
      checkResetOutputs("rst");
      @(negedge clock);
      resetn  = 1'b1;
      inValid = 1'b0;
      inTag   = 4'h0;

      // Single block tag 3, completion plus admission of tag 5 at cycle 20, tag 6 at 21.
      $display("[TB] single block");
      applyStimulus(1'b1, 4'h3, 1'b0);
      checkOutput("sb_ready0", 32'(inReady), 32'd1);
      checkOutput("sb_sel0", 32'(muxSelNew), 32'd1);
      checkOutput("sb_empty0", 32'(muxEmpty), 32'd0);
      checkOutput("sb_rcon0", 32'(muxRcon), 32'h01);
      checkOutput("sb_infl0", 32'(inflight), 32'd0);
      for (int c = 1; c <= 21; c++) begin
         applyStimulus(c >= 20, (c == 20) ? 4'h5 : 4'h6, 1'b0);
         if (c % 2 == 0 && c <= 18) begin
            checkOutput($sformatf("sb_rcon%0d", c), 32'(muxRcon), 32'(rconTab[c/2]));
            checkOutput($sformatf("sb_ready%0d", c), 32'(inReady), 32'd0);
            checkOutput($sformatf("sb_sel%0d", c), 32'(muxSelNew), 32'd0);
         end else if (c < 20) begin
            checkOutput($sformatf("sb_empty%0d", c), 32'(muxEmpty), 32'd1);
         end
         checkOutput($sformatf("sb_last%0d", c), 32'(muxLastRound), 32'(c == 18));
         checkOutput($sformatf("sb_ovalid%0d", c), 32'(outValid), 32'(c == 20));
         checkOutput($sformatf("sb_infl%0d", c), 32'(inflight), 32'd1);
         if (c == 20) begin
            checkOutput("cpa_otag", 32'(outTag), 32'h3);
            checkOutput("cpa_ready", 32'(inReady), 32'd1);
            checkOutput("cpa_sel", 32'(muxSelNew), 32'd1);
            checkOutput("cpa_empty", 32'(muxEmpty), 32'd0);
            checkOutput("cpa_rcon", 32'(muxRcon), 32'h01);
         end
      end

      // Tags 5 and 6 in flight; flush at cycle 27 (seven cycles after tag 5 entered).
      $display("[TB] flush");
      for (int c = 22; c <= 27; c++) begin
         applyStimulus(1'b0, 4'h0, c == 27);
         if (c == 22) checkOutput("fl_infl22", 32'(inflight), 32'd2);
      end
      checkOutput("fl_ready", 32'(inReady), 32'd0);
      checkOutput("fl_empty", 32'(muxEmpty), 32'd1);
      checkOutput("fl_ovalid", 32'(outValid), 32'd0);

      // Idle for 50 cycles; also covers when the flushed tags would have finished.
      $display("[TB] idle");
      badCount = 0;
      for (int c = 0; c < 50; c++) begin
         applyStimulus(1'b0, 4'h0, 1'b0);
         if (c == 0) checkOutput("fl_infl_after", 32'(inflight), 32'd0);
         if (!(muxEmpty === 1'b1 && muxSelNew === 1'b1 && outValid === 1'b0)) badCount++;
      end
      checkOutput("idle_bad_cycles", 32'(badCount), 32'd0);

      // Back-to-back tags 1 and 2.
      $display("[TB] back-to-back");
      applyStimulus(1'b1, 4'h1, 1'b0);
      checkOutput("b2b_ready0", 32'(inReady), 32'd1);
      checkOutput("b2b_infl0", 32'(inflight), 32'd0);
      applyStimulus(1'b1, 4'h2, 1'b0);
      checkOutput("b2b_ready1", 32'(inReady), 32'd1);
      checkOutput("b2b_infl1", 32'(inflight), 32'd1);
      badCount = 0;
      for (int c = 2; c <= 19; c++) begin
         applyStimulus(1'b1, 4'h9, 1'b0);
         if (c == 2) checkOutput("b2b_infl2", 32'(inflight), 32'd2);
         if (inReady !== 1'b0 || outValid !== 1'b0) badCount++;
      end
      checkOutput("b2b_blocked", 32'(badCount), 32'd0);
      applyStimulus(1'b0, 4'h0, 1'b0);
      checkOutput("b2b_ovalid20", 32'(outValid), 32'd1);
      checkOutput("b2b_otag20", 32'(outTag), 32'h1);
      checkOutput("b2b_infl20", 32'(inflight), 32'd2);
      applyStimulus(1'b0, 4'h0, 1'b0);
      checkOutput("b2b_ovalid21", 32'(outValid), 32'd1);
      checkOutput("b2b_otag21", 32'(outTag), 32'h2);
      checkOutput("b2b_infl21", 32'(inflight), 32'd1);
      applyStimulus(1'b0, 4'h0, 1'b0);
      checkOutput("b2b_ovalid22", 32'(outValid), 32'd0);
      checkOutput("b2b_infl22", 32'(inflight), 32'd0);

      // Reset in the middle of tag 7, then tag A right after release.
      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 4'h7, 1'b0);
      for (int c = 1; c <= 10; c++) applyStimulus(1'b0, 4'h0, 1'b0);
      @(negedge clock);
      resetn  = 1'b0;
      inValid = 1'b1;
      inTag   = 4'h4;
      #1;
      checkResetOutputs("mrst");
      @(negedge clock);
      resetn  = 1'b1;
      inValid = 1'b1;
      inTag   = 4'hA;
      #1;
      checkOutput("mrst_accept_ready", 32'(inReady), 32'd1);
      checkOutput("mrst_accept_rcon", 32'(muxRcon), 32'h01);
      checkOutput("mrst_accept_empty", 32'(muxEmpty), 32'd0);
      badCount = 0;
      for (int c = 1; c <= 21; c++) begin
         applyStimulus(1'b0, 4'h0, 1'b0);
         if (c % 2 == 0 && c <= 18)
            checkOutput($sformatf("mrst_rcon%0d", c), 32'(muxRcon), 32'(rconTab[c/2]));
         if (c < 20 && outValid !== 1'b0) badCount++;
         if (c == 20) begin
            checkOutput("mrst_ovalid20", 32'(outValid), 32'd1);
            checkOutput("mrst_otag20", 32'(outTag), 32'hA);
         end
         if (c == 21) checkOutput("mrst_infl21", 32'(inflight), 32'd0);
      end
      checkOutput("mrst_no_ghost", 32'(badCount), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
